spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
- SPI responder (mode 0, MSB first) on the spi_sclk/spi_ss/spi_mosi/spi_miso pins.
- Oversamples the external SPI master's signals in the system clock domain and delivers received bytes as (data, valid) to data_loader's idata/ivalid.
- Shifts a status byte back on MISO, e.g. the frame-flipped/ready state.
- Replaces the UART receive path as the frame source.

Parameters:
bitwidth, 8, bits per SPI word and width of data/tx_data
sync_stages, 2, synchronizer flops per SPI input (min 2)

Ports:
clk  input  1  system clock; all logic on posedge
rst_n  input  1  synchronous reset, active-low
spi_sclk  input  1  SPI clock from master, asynchronous to clk; idle low
spi_ss  input  1  slave select from pin, active-low, asynchronous
spi_mosi  input  1  serial data from master
spi_miso  output  1  serial data to master
data  output  bitwidth  last complete received word
valid  output  1  one-clk pulse: data holds a new word
frame_start  output  1  one-clk pulse on synchronized spi_ss falling edge
tx_data  input  bitwidth  word returned on MISO; sampled at word boundaries
busy  output  1  high while synchronized spi_ss is asserted (low)

Behaviour:
- Reset (rst_n low at clk edge):
  - data=0, valid=0, frame_start=0, spi_miso=0, busy=0.
  - Bit counter=0. Shift registers=0.
  - All synchronizer stages set to idle: sclk=0, ss=1, mosi=0.
- Synchronization and edge detection:
  - Each SPI input passes through sync_stages flops, plus one delay flop for edge detection.
  - Pin-to-detected-edge latency is sync_stages+1 clks (3 at default).
- Legal SCLK timing: high and low phases each at least sync_stages+2 clk periods. Behaviour outside this is undefined.
- Frame start (synchronized ss falls):
  - frame_start pulses for 1 clk and busy goes high.
  - Bit counter clears; rx shift register clears.
  - tx shift register loads tx_data; spi_miso = tx_data[bitwidth-1] from the next clk.
- SCLK rising edge while busy:
  - rx_shift <= {rx_shift[bitwidth-2:0], mosi_sync}; counter increments.
  - When the counter reaches bitwidth-1 on this edge, the word completes: on the next clk, data <= full word and valid=1 for exactly 1 clk. Counter wraps to 0.
  - The tx shift register reloads from tx_data on word completion, so back-to-back words need no ss toggle.
- SCLK falling edge while busy: tx shift register shifts left; spi_miso = new MSB. The falling edge that follows the word-completing rising edge outputs the MSB of the reloaded word and does not shift.
- Frame end (synchronized ss rises):
  - busy=0, spi_miso=0 next clk.
  - A partial word (counter != 0) is discarded with no valid. data keeps its previous value.
- SCLK edges with ss deasserted are ignored.
- If ss rises and the 8th rising edge are detected in the same clk, the word is delivered (valid=1) before deassertion takes effect.
- valid has no backpressure. The consumer must accept every pulse; minimum spacing between pulses is 2*bitwidth*(sync_stages+2) clks.
- rst_n low mid-word aborts the word with no valid. After release, the block waits for a fresh ss falling edge before capturing.

Optional Feature:
Macro SPI_SLAVE_RX_OVERRUN_EN.
- Defined:
  - Adds input ready (1) and output overrun (1).
  - valid becomes level: it stays high holding data until a clk with valid&&ready, and drops the following clk.
  - If a new word completes while valid=1 and ready=0, the new word is dropped, data is kept, and overrun sets.
  - overrun is sticky; it clears on frame_start or reset.
- Undefined: ports absent; valid is a 1-clk pulse exactly as above.

Test Plan:
- Reset: hold rst_n=0 3 clks with pins toggling -> all outputs 0; no valid, no frame_start.
- Single word: ss low, send 0xA5 mode 0 at clk/10 with tx_data=0x3C -> frame_start once; valid one clk with data=0xA5; master samples 0x3C on MISO.
- Burst: 4 words 0x01,0x80,0xFF,0x00 in one ss assertion; tx_data changed to 0x11,0x22,0x33 after each valid -> 4 valid pulses in order. MISO returns 0x3C,0x11,0x22,0x33 (tx_data is sampled at each word boundary, so each returned word is the tx_data value loaded when the previous word completed).
- Abort: ss rises after 5 bits of 0x5A, then a full frame with 0xC3 -> no valid for the partial word; next valid data=0xC3.
- Reset mid-word: rst_n low after 3 bits, then released with ss still low and 5 more bits clocked -> no valid until ss toggles high then low; a full word after that is received correctly.
- With SPI_SLAVE_RX_OVERRUN_EN, ready=0: send 0x10 then 0x20 -> data=0x10 with valid held and overrun=1. Raise ready -> valid drops. Next frame_start clears overrun.

Source files
------------

// File: rtl/spi_slave_rx.sv
// rtl/spi_slave_rx.sv - SPI mode-0 responder, oversampled in the clk domain (option: SPI_SLAVE_RX_OVERRUN_EN)
module spi_slave_rx #(
  parameter int bitwidth    = 8,
  parameter int sync_stages = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spi_sclk,
  input  logic                spi_ss,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic [bitwidth-1:0] data,
  output logic                valid,
  output logic                frame_start,
  input  logic [bitwidth-1:0] tx_data,
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  input  logic                ready,
  output logic                overrun,
`endif
  output logic                busy
);

  localparam int cw = (bitwidth > 2) ? $clog2(bitwidth) : 1;
  localparam logic [cw-1:0] last_bit = cw'(bitwidth - 1);
  localparam int fw = $clog2(sync_stages + 2);
  localparam logic [fw-1:0] flush_done = fw'(sync_stages + 1);

  logic [sync_stages-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_d, ss_d;
  logic                   sclk_s, ss_s, mosi_s;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [fw-1:0]          flush_cnt;
  logic                   armed;
  logic [cw-1:0]          bit_cnt;
  logic [bitwidth-1:0]    rx_shift, tx_shift, rx_next;
  logic                   tx_hold;

  assign sclk_s    = sclk_sync[sync_stages-1];
  assign ss_s      = ss_sync[sync_stages-1];
  assign mosi_s    = mosi_sync[sync_stages-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign ss_fall   = ~ss_s & ss_d;
  assign ss_rise   = ss_s & ~ss_d;
  assign rx_next   = {rx_shift[bitwidth-2:0], mosi_s};

  // armed stays low after reset until the pipeline has flushed and ss is seen idle,
  // so a select already held low across reset cannot start a frame mid-word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync   <= '0;
      ss_sync     <= '1;
      mosi_sync   <= '0;
      sclk_d      <= 1'b0;
      ss_d        <= 1'b1;
      flush_cnt   <= '0;
      armed       <= 1'b0;
      bit_cnt     <= '0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_hold     <= 1'b0;
      data        <= '0;
      valid       <= 1'b0;
      frame_start <= 1'b0;
      spi_miso    <= 1'b0;
      busy        <= 1'b0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
      overrun     <= 1'b0;
`endif
    end else begin
      sclk_sync <= {sclk_sync[sync_stages-2:0], spi_sclk};
      ss_sync   <= {ss_sync[sync_stages-2:0], spi_ss};
      mosi_sync <= {mosi_sync[sync_stages-2:0], spi_mosi};
      sclk_d    <= sclk_s;
      ss_d      <= ss_s;

      if (flush_cnt != flush_done) begin
        flush_cnt <= flush_cnt + 1'b1;
      end else if (ss_s) begin
        armed <= 1'b1;
      end

      frame_start <= 1'b0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
      if (valid && ready) begin
        valid <= 1'b0;
      end
`else
      valid <= 1'b0;
`endif

      if (busy && sclk_rise) begin
        rx_shift <= rx_next;
        if (bit_cnt == last_bit) begin
          bit_cnt  <= '0;
          tx_shift <= tx_data;
          tx_hold  <= 1'b1;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
          if (valid && !ready) begin
            overrun <= 1'b1;
          end else begin
            data  <= rx_next;
            valid <= 1'b1;
          end
`else
          data  <= rx_next;
          valid <= 1'b1;
`endif
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end

      // After a reload the MSB is already at the top of tx_shift, so present it unshifted.
      if (busy && sclk_fall) begin
        if (tx_hold) begin
          spi_miso <= tx_shift[bitwidth-1];
          tx_hold  <= 1'b0;
        end else begin
          tx_shift <= {tx_shift[bitwidth-2:0], 1'b0};
          spi_miso <= tx_shift[bitwidth-2];
        end
      end

      if (ss_fall && armed) begin
        frame_start <= 1'b1;
        busy        <= 1'b1;
        bit_cnt     <= '0;
        rx_shift    <= '0;
        tx_shift    <= tx_data;
        tx_hold     <= 1'b0;
        spi_miso    <= tx_data[bitwidth-1];
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        overrun     <= 1'b0;
`endif
      end else if (ss_rise && busy) begin
        busy     <= 1'b0;
        spi_miso <= 1'b0;
        bit_cnt  <= '0;
        tx_hold  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb/tb_spi_slave_rx.sv - directed scoreboard bench for spi_slave_rx (option: SPI_SLAVE_RX_OVERRUN_EN)
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       rst_n, spi_sclk, spi_ss, spi_mosi, spi_miso;
  logic [7:0] data, tx_data;
  logic       valid, frame_start, busy;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
  logic       ready = 1'b1;
  logic       overrun;
`endif

  int         tests = 0;
  int         fails = 0;
  int         fs_cnt = 0;
  int         v_cnt = 0;
  int         exp_v_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mi;
  logic [7:0] exp_word;

  always #5 clk = ~clk;

  spi_slave_rx #(.bitwidth(8), .sync_stages(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_ss(spi_ss), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .data(data), .valid(valid), .frame_start(frame_start),
    .tx_data(tx_data),
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    .ready(ready), .overrun(overrun),
`endif
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Mode-0 master: drive MOSI while SCLK low, sample MISO on the rising edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, input logic [7:0] next_tx,
                      output logic [7:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = mo[7-i];
      clks(5);
      spi_sclk = 1'b1;
      got = {got[6:0], spi_miso};
      if (i == 0) tx_data = next_tx;
      clks(5);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] mo, input logic [7:0] next_tx, output logic [7:0] got);
    exp_q.push_back(mo);
    exp_v_cnt++;
    xfer(mo, 8, next_tx, got);
  endtask

  task automatic ss_low();
    spi_ss = 1'b0;
    clks(10);
  endtask

  task automatic ss_high();
    clks(5);
    spi_ss = 1'b1;
    clks(10);
  endtask

  // Output monitor: every delivered word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    if (valid && ready) begin
`else
    if (valid) begin
`endif
      v_cnt++;
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL unexpected_valid: observed data %0h expected no word", data);
      end
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        check("rx_data", data, exp_word);
      end
    end
  end

  initial begin
    rst_n = 1'b0; spi_sclk = 1'b0; spi_ss = 1'b1; spi_mosi = 1'b0; tx_data = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      clks(1);
      spi_sclk = ~spi_sclk; spi_ss = ~spi_ss; spi_mosi = ~spi_mosi;
    end
    check("reset_out", {data, valid, frame_start, spi_miso, busy}, 12'h000);
    spi_sclk = 1'b0; spi_ss = 1'b1; spi_mosi = 1'b0;
    clks(1);
    rst_n = 1'b1;
    clks(10);
    check("reset_fs", fs_cnt, 0);
    check("reset_valid", v_cnt, 0);

    // Single word
    ss_low();
    check("single_fs", fs_cnt, 1);
    check("single_busy", busy, 1);
    send(8'hA5, 8'h3C, mi);
    clks(5);
    check("single_miso", mi, 8'h3C);
    check("single_vcnt", v_cnt, exp_v_cnt);
    ss_high();
    check("end_busy", busy, 0);
    check("end_miso", spi_miso, 0);

    // Burst of four words in one select
    tx_data = 8'h3C;
    ss_low();
    send(8'h01, 8'h11, mi); check("burst_miso0", mi, 8'h3C);
    send(8'h80, 8'h22, mi); check("burst_miso1", mi, 8'h11);
    send(8'hFF, 8'h33, mi); check("burst_miso2", mi, 8'h22);
    send(8'h00, 8'h33, mi); check("burst_miso3", mi, 8'h33);
    ss_high();
    check("burst_vcnt", v_cnt, exp_v_cnt);
    check("burst_fs", fs_cnt, 2);

    // Abort after five bits, then a full frame
    ss_low();
    xfer(8'h5A, 5, 8'h3C, mi);
    ss_high();
    check("abort_data", data, 8'h00);
    check("abort_vcnt", v_cnt, exp_v_cnt);
    ss_low();
    send(8'hC3, 8'h3C, mi);
    ss_high();
    check("abort_next", data, 8'hC3);

    // Reset in mid-word with select held low
    ss_low();
    xfer(8'h96, 3, 8'h3C, mi);
    rst_n = 1'b0;
    clks(3);
    check("midrst_data", data, 8'h00);
    rst_n = 1'b1;
    clks(2);
    xfer(8'hFF, 5, 8'h3C, mi);
    clks(10);
    check("midrst_busy", busy, 0);
    check("midrst_vcnt", v_cnt, exp_v_cnt);
    spi_ss = 1'b1;
    clks(10);
    ss_low();
    check("midrst_fs", busy, 1);
    send(8'h69, 8'h3C, mi);
    ss_high();
    check("midrst_word", data, 8'h69);

`ifdef SPI_SLAVE_RX_OVERRUN_EN
    ready = 1'b0;
    ss_low();
    exp_q.push_back(8'h10);
    exp_v_cnt++;
    xfer(8'h10, 8, 8'h3C, mi);
    xfer(8'h20, 8, 8'h3C, mi);
    clks(5);
    check("ovr_data", data, 8'h10);
    check("ovr_valid", valid, 1);
    check("ovr_flag", overrun, 1);
    ready = 1'b1;
    clks(2);
    check("ovr_drop", valid, 0);
    ss_high();
    ss_low();
    check("ovr_clear", overrun, 0);
    ss_high();
`endif

    clks(20);
    check("final_vcnt", v_cnt, exp_v_cnt);
    check("final_queue", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
